lcc_rx_parser: RTL and testbench

- Frames the LCC response byte stream coming out of the LCC UART receiver (one byte per valid strobe) into fixed-length packets.
- Checks the header, the request number and the checksum of each packet.
- Holds the last good payload word for SKUT_former (its LKF/DDC inputs).
- Runs on the 80 MHz system clock, directly downstream of the UART receiver. The request strobe and request number come from SKUT_former's LCC request outputs.

---
 rtl/lcc_rx_parser.sv | 132 +++++++++++++
 tb/tb_lcc_rx_parser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lcc_rx_parser.sv
// Frames the LCC UART response stream into HEADER/NUM/payload/CS packets.
// Checks each packet and holds the last good payload word for SKUT_former.
module lcc_rx_parser #(
    parameter int          BYTES   = 4,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd8064
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  iData,
    input  logic        iValid,
    input  logic        iRq,
    input  logic [7:0]  iCycle,
    output logic [31:0] oWord,
    output logic        oValid,
    output logic        oErr,
    output logic [1:0]  oErrCode,
    output logic [7:0]  oGood
);

    typedef enum logic [1:0] {S_IDLE, S_NUM, S_PAY, S_CS} state_t;

    localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);
    localparam int         ALIGN_SH = 8 * (4 - BYTES);

    state_t      state, state_nxt;
    logic [7:0]  exp_num;
    logic [7:0]  sum;
    logic        num_mis;
    logic [31:0] payload;
    logic [1:0]  idx;
    logic [15:0] tmo_cnt;

    logic        ok_pulse, err_pulse;
    logic [1:0]  err_code_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // A request always wins over a byte in the same clock; a byte always
    // wins over an expiring timeout.
    always_comb begin
        state_nxt    = state;
        ok_pulse     = 1'b0;
        err_pulse    = 1'b0;
        err_code_nxt = oErrCode;
        if (iRq) begin
            if (state != S_IDLE) begin
                state_nxt    = S_IDLE;
                err_pulse    = 1'b1;
                err_code_nxt = 2'd3;
            end
        end else if (iValid) begin
            case (state)
                S_IDLE: if (iData == HEADER) state_nxt = S_NUM;
                S_NUM:  state_nxt = S_PAY;
                S_PAY:  if (idx == LAST_IDX) state_nxt = S_CS;
                S_CS: begin
                    state_nxt = S_IDLE;
                    if (iData != sum) begin
                        err_pulse    = 1'b1;
                        err_code_nxt = 2'd0;
                    end else if (num_mis) begin
                        err_pulse    = 1'b1;
                        err_code_nxt = 2'd1;
                    end else begin
                        ok_pulse = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo_cnt == TIMEOUT) begin
            state_nxt    = S_IDLE;
            err_pulse    = 1'b1;
            err_code_nxt = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oWord    <= '0;
            oValid   <= 1'b0;
            oErr     <= 1'b0;
            oErrCode <= '0;
            oGood    <= '0;
            exp_num  <= '0;
            sum      <= '0;
            num_mis  <= 1'b0;
            payload  <= '0;
            idx      <= '0;
            tmo_cnt  <= '0;
        end else begin
            oValid <= ok_pulse;
            oErr   <= err_pulse;
            if (err_pulse) oErrCode <= err_code_nxt;
            if (ok_pulse) begin
                oWord <= payload << ALIGN_SH;
                oGood <= oGood + 8'd1;
            end

            if (iRq) exp_num <= iCycle;

            if (state_nxt == S_IDLE || iValid) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + 16'd1;

            if (!iRq && iValid) begin
                case (state)
                    S_IDLE: if (iData == HEADER) begin
                        sum     <= '0;
                        payload <= '0;
                        num_mis <= 1'b0;
                        idx     <= '0;
                    end
                    S_NUM: begin
                        sum     <= iData;
                        num_mis <= (iData != exp_num);
                        idx     <= '0;
                    end
                    S_PAY: begin
                        payload <= {payload[23:0], iData};
                        sum     <= sum + iData;
                        idx     <= idx + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcc_rx_parser.sv
// Directed bench for lcc_rx_parser: good/bad packets, timeout, abort, wrap, reset.
module tb_lcc_rx_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  iData = 8'h00;
    logic        iValid = 1'b0;
    logic        iRq = 1'b0;
    logic [7:0]  iCycle = 8'h00;
    logic [31:0] oWord;
    logic        oValid;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic [7:0]  oGood;

    int checks = 0;
    int fails  = 0;
    int n_err  = 0;
    int n_val  = 0;
    int n_both = 0;
    logic [7:0] exp_good = 8'd0;

    lcc_rx_parser dut (
        .clk(clk), .reset(reset), .iData(iData), .iValid(iValid),
        .iRq(iRq), .iCycle(iCycle), .oWord(oWord), .oValid(oValid),
        .oErr(oErr), .oErrCode(oErrCode), .oGood(oGood)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (oErr) n_err++;
        if (oValid) n_val++;
        if (oErr && oValid) n_both++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        iData = b; iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
    endtask

    task automatic do_rq(input logic [7:0] c);
        @(negedge clk);
        iRq = 1'b1; iCycle = c;
        @(negedge clk);
        iRq = 1'b0;
    endtask

    // Returns at the negedge one clock after the CS byte was sampled.
    task automatic send_pkt(input logic [7:0] num, input logic [31:0] pl,
                            input logic [7:0] cs, input int gap);
        send_byte(8'hA5); idle(gap);
        send_byte(num);   idle(gap);
        send_byte(pl[31:24]); idle(gap);
        send_byte(pl[23:16]); idle(gap);
        send_byte(pl[15:8]);  idle(gap);
        send_byte(pl[7:0]);   idle(gap);
        send_byte(cs);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (oWord !== 32'h0) begin fails++; $display("FAIL reset_oWord got %h want 0", oWord); end
        checks++; if (oValid !== 1'b0 || oErr !== 1'b0) begin fails++; $display("FAIL reset_pulses got v=%b e=%b want 0 0", oValid, oErr); end
        checks++; if (oErrCode !== 2'd0) begin fails++; $display("FAIL reset_code got %0d want 0", oErrCode); end
        checks++; if (oGood !== 8'd0) begin fails++; $display("FAIL reset_good got %0d want 0", oGood); end
        idle(2);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_good();
        int e0;
        e0 = n_err;
        do_rq(8'h03);
        idle(10);
        send_pkt(8'h03, 32'h11223344, 8'hAD, 10);
        exp_good++;
        checks++; if (oValid !== 1'b1) begin fails++; $display("FAIL good_valid got %b want 1", oValid); end
        checks++; if (oWord !== 32'h11223344) begin fails++; $display("FAIL good_word got %h want 11223344", oWord); end
        checks++; if (oGood !== exp_good) begin fails++; $display("FAIL good_count got %0d want %0d", oGood, exp_good); end
        idle(1);
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL good_single got %b want 0", oValid); end
        checks++; if (n_err != e0) begin fails++; $display("FAIL good_noerr got %0d errs want 0", n_err - e0); end
    endtask

    task automatic test_checksum();
        send_pkt(8'h03, 32'h11223344, 8'hAE, 1);
        checks++; if (oErr !== 1'b1 || oErrCode !== 2'd0) begin fails++; $display("FAIL cs_err got e=%b c=%0d want 1 0", oErr, oErrCode); end
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL cs_novalid got %b want 0", oValid); end
        checks++; if (oWord !== 32'h11223344 || oGood !== exp_good) begin fails++; $display("FAIL cs_hold got %h/%0d want 11223344/%0d", oWord, oGood, exp_good); end
        idle(1);
        checks++; if (oErr !== 1'b0 || oErrCode !== 2'd0) begin fails++; $display("FAIL cs_single got e=%b c=%0d want 0 0", oErr, oErrCode); end
    endtask

    task automatic test_mismatch();
        send_pkt(8'h04, 32'h11223344, 8'hAE, 1);
        checks++; if (oErr !== 1'b1 || oErrCode !== 2'd1) begin fails++; $display("FAIL mis_err got e=%b c=%0d want 1 1", oErr, oErrCode); end
        checks++; if (oGood !== exp_good) begin fails++; $display("FAIL mis_good got %0d want %0d", oGood, exp_good); end
        idle(2);
        checks++; if (oErrCode !== 2'd1) begin fails++; $display("FAIL mis_codehold got %0d want 1", oErrCode); end
    endtask

    task automatic test_timeout();
        int cnt, e0;
        bit seen;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        e0 = n_err; cnt = 0; seen = 0;
        while (cnt < 9000 && !seen) begin
            @(negedge clk); cnt++;
            if (oErr) seen = 1;
        end
        checks++; if (!seen) begin fails++; $display("FAIL tmo_seen got none in %0d clocks want err", cnt); end
        checks++; if (cnt < 8064 || cnt > 8066) begin fails++; $display("FAIL tmo_time got %0d clocks want 8064..8066", cnt); end
        checks++; if (oErrCode !== 2'd2) begin fails++; $display("FAIL tmo_code got %0d want 2", oErrCode); end
        checks++; if (n_err - e0 != 1) begin fails++; $display("FAIL tmo_once got %0d want 1", n_err - e0); end
        idle(3);
        send_pkt(8'h03, 32'hDEADBEEF, 8'h03 + 8'hDE + 8'hAD + 8'hBE + 8'hEF, 0);
        exp_good++;
        checks++; if (oValid !== 1'b1 || oWord !== 32'hDEADBEEF) begin fails++; $display("FAIL tmo_after got v=%b w=%h want 1 deadbeef", oValid, oWord); end
    endtask

    task automatic test_abort_sim();
        int e0, v0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        do_rq(8'h03);
        checks++; if (oErr !== 1'b1 || oErrCode !== 2'd3) begin fails++; $display("FAIL abort_err got e=%b c=%0d want 1 3", oErr, oErrCode); end
        idle(2);
        e0 = n_err; v0 = n_val;
        @(negedge clk);
        iRq = 1'b1; iCycle = 8'h03; iData = 8'hA5; iValid = 1'b1;
        @(negedge clk);
        iRq = 1'b0; iValid = 1'b0;
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'hAD);
        idle(2);
        checks++; if (n_err != e0 || n_val != v0) begin fails++; $display("FAIL sim_ignored got err=%0d val=%0d want 0 0", n_err - e0, n_val - v0); end
        send_byte(8'h00); send_byte(8'hFF);
        send_pkt(8'h03, 32'h01020304, 8'h0D, 0);
        exp_good++;
        checks++; if (oValid !== 1'b1 || oWord !== 32'h01020304) begin fails++; $display("FAIL junk_pkt got v=%b w=%h want 1 01020304", oValid, oWord); end
        checks++; if (n_err != e0) begin fails++; $display("FAIL junk_noerr got %0d want 0", n_err - e0); end
    endtask

    task automatic test_wrap();
        int v0;
        v0 = n_val;
        while (exp_good != 8'd0) begin
            send_pkt(8'h03, 32'h11223344, 8'hAD, 0);
            exp_good++;
            if (exp_good == 8'd255) begin
                checks++; if (oGood !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d want 255", oGood); end
            end
        end
        checks++; if (oGood !== 8'd0) begin fails++; $display("FAIL wrap_zero got %0d want 0", oGood); end
        checks++; if (n_both != 0) begin fails++; $display("FAIL excl got %0d overlaps want 0", n_both); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        #3 reset = 1'b0;
        #1;
        checks++; if (oWord !== 32'h0 || oGood !== 8'd0 || oErrCode !== 2'd0 || oValid !== 1'b0 || oErr !== 1'b0) begin
            fails++; $display("FAIL rst_mid got w=%h g=%0d c=%0d v=%b e=%b want all 0", oWord, oGood, oErrCode, oValid, oErr);
        end
        idle(2);
        reset = 1'b1;
        do_rq(8'h03);
        send_pkt(8'h03, 32'h11223344, 8'hAD, 0);
        checks++; if (oValid !== 1'b1 || oGood !== 8'd1 || oWord !== 32'h11223344) begin
            fails++; $display("FAIL rst_after got v=%b g=%0d w=%h want 1 1 11223344", oValid, oGood, oWord);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_checksum();
        test_mismatch();
        test_timeout();
        test_abort_sim();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
